fetch_decode_queue: RTL and testbench

- Consumer end of the instruction-fetch interface. Accepts {pc, instr} pairs from the fetch stage and buffers them in a small FIFO.
- Presents the head entry to decode with a valid/ready handshake, together with the extracted RV32I fields and a sign-extended immediate.
- Its ready output drives the PC register's pc_write, so fetch stalls whenever the queue is full.

---
 rtl/fetch_decode_queue.sv | 119 +++++++++++
 tb/tb_fetch_decode_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Instruction-fetch consumer queue: buffers {pc, instr} pairs and presents the
// head entry to decode with RV32I field extraction and immediate generation.
module fetch_decode_queue #(
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fq_valid_in,
   input  logic [31:0]          fq_pc_in,
   input  logic [31:0]          fq_instr_in,
   output logic                 fq_ready_out,
   input  logic                 flush,
   input  logic                 dec_ready_in,
   output logic                 dec_valid_out,
   output logic [31:0]          dec_pc,
   output logic [31:0]          dec_instr,
   output logic [6:0]           dec_opcode,
   output logic [4:0]           dec_rd,
   output logic [2:0]           dec_funct3,
   output logic [4:0]           dec_rs1,
   output logic [4:0]           dec_rs2,
   output logic [6:0]           dec_funct7,
   output logic [31:0]          dec_imm,
   output logic                 dec_illegal,
   output logic [PTR_WIDTH:0]   count
);

   localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

   logic [31:0]          pc_mem    [DEPTH];
   logic [31:0]          instr_mem [DEPTH];
   logic [PTR_WIDTH-1:0] wptr;
   logic [PTR_WIDTH-1:0] rptr;
   logic                 push;
   logic                 pop;
   logic [31:0]          head;

   function automatic logic is_legal(input logic [6:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111,
         7'b0100011, 7'b1100011,
         7'b0110111, 7'b0010111,
         7'b1101111, 7'b0110011: ok = 1'b1;
         default:               ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] imm_of(input logic [31:0] ins);
      logic [31:0] imm;
      imm = '0;
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111:
            imm = {{20{ins[31]}}, ins[31:20]};
         7'b0100011:
            imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         7'b1100011:
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm = {ins[31:12], 12'b0};
         7'b1101111:
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:
            imm = '0;
      endcase
      return imm;
   endfunction

   // Ready depends only on registered occupancy, so a full queue never
   // accepts a push even when decode drains it in the same cycle.
   assign fq_ready_out  = (count != FULL_COUNT);
   assign dec_valid_out = (count != '0);
   assign push          = fq_valid_in && fq_ready_out && !flush;
   assign pop           = dec_valid_out && dec_ready_in && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage holds data only; its contents are irrelevant while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr]    <= fq_pc_in;
         instr_mem[wptr] <= fq_instr_in;
      end
   end

   assign head        = instr_mem[rptr];
   assign dec_pc      = pc_mem[rptr];
   assign dec_instr   = head;
   assign dec_opcode  = head[6:0];
   assign dec_rd      = head[11:7];
   assign dec_funct3  = head[14:12];
   assign dec_rs1     = head[19:15];
   assign dec_rs2     = head[24:20];
   assign dec_funct7  = head[31:25];
   assign dec_imm     = imm_of(head);
   assign dec_illegal = dec_valid_out && !is_legal(head[6:0]);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
   localparam int PTR_WIDTH = 2;

   logic        clk;
   logic        reset;
   logic        fq_valid_in;
   logic [31:0] fq_pc_in;
   logic [31:0] fq_instr_in;
   logic        fq_ready_out;
   logic        flush;
   logic        dec_ready_in;
   logic        dec_valid_out;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic [6:0]  dec_opcode;
   logic [4:0]  dec_rd;
   logic [2:0]  dec_funct3;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [6:0]  dec_funct7;
   logic [31:0] dec_imm;
   logic        dec_illegal;
   logic [PTR_WIDTH:0] count;

   int total = 0;
   int bad   = 0;

   logic [63:0] mq [$];
   logic [31:0] next_pc;

   fetch_decode_queue #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) dut (
      .clk(clk), .reset(reset),
      .fq_valid_in(fq_valid_in), .fq_pc_in(fq_pc_in), .fq_instr_in(fq_instr_in),
      .fq_ready_out(fq_ready_out), .flush(flush), .dec_ready_in(dec_ready_in),
      .dec_valid_out(dec_valid_out), .dec_pc(dec_pc), .dec_instr(dec_instr),
      .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_funct3(dec_funct3),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct7(dec_funct7),
      .dec_imm(dec_imm), .dec_illegal(dec_illegal), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic model_legal(input logic [31:0] i);
      logic [6:0] op;
      op = i[6:0];
      return (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h23 || op == 7'h63 ||
              op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h33);
   endfunction

   // Immediates via arithmetic shifts of the signed word and OR-ed bit fields.
   function automatic logic [31:0] model_imm(input logic [31:0] i);
      logic [31:0] top20;
      logic [31:0] sgn;
      logic [6:0]  op;
      op    = i[6:0];
      top20 = $signed(i) >>> 20;
      sgn   = $signed(i) >>> 31;
      if (op == 7'h03 || op == 7'h13 || op == 7'h67) return top20;
      if (op == 7'h23) return (top20 & ~32'h1F) | 32'(i[11:7]);
      if (op == 7'h63) return (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      if (op == 7'h37 || op == 7'h17) return i & 32'hFFFF_F000;
      if (op == 7'h6F) return (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      return 32'h0;
   endfunction

   task automatic compare_all();
      logic [31:0] ei;
      check("count", 32'(count), 32'(mq.size()));
      check("ready", 32'(fq_ready_out), 32'(mq.size() != DEPTH));
      check("valid", 32'(dec_valid_out), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         ei = mq[0][31:0];
         check("pc", dec_pc, mq[0][63:32]);
         check("instr", dec_instr, ei);
         check("fields", {dec_funct7, dec_rs2, dec_rs1, dec_funct3, dec_rd, dec_opcode}, ei);
         check("imm", dec_imm, model_imm(ei));
         check("illegal", 32'(dec_illegal), 32'(!model_legal(ei)));
      end else begin
         check("illegal_empty", 32'(dec_illegal), 32'h0);
      end
   endtask

   // Inputs must already be driven; advance one edge and update the model.
   task automatic cycle();
      logic do_push, do_pop;
      do_push = fq_valid_in && (mq.size() != DEPTH) && !flush;
      do_pop  = dec_ready_in && (mq.size() != 0) && !flush;
      @(posedge clk);
      #1;
      if (flush) mq.delete();
      else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({fq_pc_in, fq_instr_in});
      end
      compare_all();
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
      fq_valid_in  = v;
      fq_pc_in     = pc;
      fq_instr_in  = ins;
      dec_ready_in = rdy;
      flush        = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [12];
      logic [31:0] w;
      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00, 7'h7F, 7'h0B};
      w = $urandom;
      if ($urandom_range(0, 15) == 0) return 32'h0;
      return {w[31:7], ops[$urandom_range(0, 11)]};
   endfunction

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      check("rst_count", 32'(count), 32'h0);
      check("rst_ready", 32'(fq_ready_out), 32'h1);
      check("rst_valid", 32'(dec_valid_out), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // addi x1,x0,5 with decode stalled
      drive(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("t1_opcode", 32'(dec_opcode), 32'h13);
      check("t1_rd", 32'(dec_rd), 32'h1);
      check("t1_imm", dec_imm, 32'h5);
      check("t1_count", 32'(count), 32'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();

      // sw then beq, then drain in order
      drive(1'b1, 32'h4, 32'h0020_A423, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'h8, 32'hFE00_0EE3, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("t2_rs1", 32'(dec_rs1), 32'h1);
      check("t2_rs2", 32'(dec_rs2), 32'h2);
      check("t2_imm_sw", dec_imm, 32'h8);
      cycle();
      check("t2_imm_beq", dec_imm, 32'hFFFF_FFFC);
      cycle();
      check("t2_count", 32'(count), 32'h0);

      // Fill to full; fifth pair is held until a pop frees a slot
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'(k * 4), rand_instr(), 1'b0, 1'b0);
         cycle();
      end
      check("t3_full_count", 32'(count), 32'h4);
      check("t3_full_ready", 32'(fq_ready_out), 32'h0);
      check("t3_head_pc", dec_pc, 32'h0);
      dec_ready_in = 1'b1;
      cycle();
      dec_ready_in = 1'b0;
      check("t3_after_pop", 32'(count), 32'h3);
      cycle();
      check("t3_refill", 32'(count), 32'h4);
      check("t3_tail_pc", mq[3][63:32], 32'h10);
      fq_valid_in = 1'b0;
      dec_ready_in = 1'b1;
      repeat (4) cycle();

      // Steady-state streaming at occupancy 2
      next_pc = 32'h100;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, next_pc, rand_instr(), 1'b0, 1'b0);
         next_pc += 4;
         cycle();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, next_pc, rand_instr(), 1'b1, 1'b0);
         next_pc += 4;
         cycle();
         check("t4_count", 32'(count), 32'h2);
         check("t4_pc", dec_pc, 32'h100 + 32'((k + 1) * 4));
      end

      // Flush with count 3 while pushing and popping
      drive(1'b1, 32'h200, rand_instr(), 1'b0, 1'b0);
      cycle();
      check("t5_pre_count", 32'(count), 32'h3);
      drive(1'b1, 32'h204, rand_instr(), 1'b1, 1'b1);
      cycle();
      check("t5_count", 32'(count), 32'h0);
      check("t5_valid", 32'(dec_valid_out), 32'h0);
      check("t5_ready", 32'(fq_ready_out), 32'h1);

      // Asynchronous reset between edges with count 2
      drive(1'b1, 32'h300, rand_instr(), 1'b0, 1'b0);
      repeat (2) cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("t6_count", 32'(count), 32'h0);
      check("t6_valid", 32'(dec_valid_out), 32'h0);
      mq.delete();
      #1;
      reset = 1'b1;
      drive(1'b1, 32'h400, 32'h0, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("t6_illegal", 32'(dec_illegal), 32'h1);
      check("t6_imm", dec_imm, 32'h0);

      // Randomized traffic
      next_pc = 32'h1000;
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 9) < 7, next_pc, rand_instr(),
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         if (fq_valid_in && mq.size() != DEPTH && !flush) next_pc += 4;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
